fifo_sched: RTL and testbench

- Single-clock scheduler for the 32x24 RAM-backed FIFO.
- Turns write/read requests into RAM write/read strobes, addresses and occupancy flags. Requests come from debounced pushbuttons (manual) or divider ticks (auto).
- Sits between the clock dividers/keys and the RAM.
- A 3-state FSM serialises one transfer slot per request pair. Pending requests are held so single-cycle ticks are never lost.

---
 rtl/fifo_sched_pkg.sv | 13 +
 rtl/fifo_sched_if.sv | 25 ++
 rtl/fifo_sched_edge_det.sv | 21 ++
 rtl/fifo_sched.sv | 123 ++++++++++++
 tb/tb_fifo_sched.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared sizing and FSM encoding for the RAM-backed FIFO scheduler.
// No latency or backpressure: constants and types only.
package fifo_pkg;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_RDLAT
    } fifo_state_t;
endpackage

// File: rtl/fifo_sched_if.sv
// RAM strobe/address and occupancy bundle from the scheduler to the RAM side.
// Pure wiring, no latency; the RAM side never backpressures.
interface fifo_sched_if
    import fifo_pkg::*;
();
    logic          wren;
    logic [AW-1:0] wraddr;
    logic          rden;
    logic [AW-1:0] rdaddr;
    logic [CW-1:0] fifolen;
    logic          full;
    logic          empty;
    logic          rd_valid;
    logic          ovf_err;
    logic          udf_err;

    modport master (
        output wren, wraddr, rden, rdaddr, fifolen, full, empty,
               rd_valid, ovf_err, udf_err
    );
    modport slave (
        input  wren, wraddr, rden, rdaddr, fifolen, full, empty,
               rd_valid, ovf_err, udf_err
    );
endinterface

// File: rtl/fifo_sched_edge_det.sv
// Rising-edge detector for a debounced key; pulse is combinational off one register.
// No backpressure; the pulse lasts exactly one cycle.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic rise_o
);
    logic din_q;

    // Reset tracks the live level so a key held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= din_i;
        end else begin
            din_q <= din_i;
        end
    end

    assign rise_o = din_i & ~din_q;
endmodule

// File: rtl/fifo_sched.sv
// Serialises write/read requests into one RAM transfer slot; XFER 2 cycles after a request, rd_valid 1 later.
// No backpressure: requests are latched as pending, overlapping ones are dropped and flagged.
module fifo_sched
    import fifo_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         auto_en,
    input  logic         wr_tick,
    input  logic         rd_tick,
    input  logic         push_btn,
    input  logic         pop_btn,
    fifo_sched_if.master ram
);
    logic push_rise, pop_rise, wreq, rreq;
    logic full, empty, clr_pend, acc_wr, acc_rd;

    fifo_state_t   state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW-1:0] wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic          wren_q, wren_d, rden_q, rden_d, rd_valid_q, rd_valid_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;

    edge_det u_push_edge (.clk(clk), .reset(reset), .din_i(push_btn), .rise_o(push_rise));
    edge_det u_pop_edge  (.clk(clk), .reset(reset), .din_i(pop_btn),  .rise_o(pop_rise));

    assign wreq  = auto_en ? wr_tick : push_rise;
    assign rreq  = auto_en ? rd_tick : pop_rise;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    assign clr_pend = (state_q == S_IDLE) && (pend_wr_q || pend_rd_q);
    assign acc_wr   = pend_wr_q && !full;
    assign acc_rd   = pend_rd_q && !empty;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        wraddr_d   = wraddr_q;
        rdaddr_d   = rdaddr_q;
        cnt_d      = cnt_q;
        wren_d     = 1'b0;
        rden_d     = 1'b0;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        // A request arriving in the same cycle the latch is consumed becomes the next pending one.
        pend_wr_d = clr_pend ? wreq : (pend_wr_q || wreq);
        pend_rd_d = clr_pend ? rreq : (pend_rd_q || rreq);
        if (wreq && pend_wr_q && !clr_pend) ovf_d = 1'b1;
        if (rreq && pend_rd_q && !clr_pend) udf_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (clr_pend) begin
                    state_d  = S_XFER;
                    wren_d   = acc_wr;
                    rden_d   = acc_rd;
                    wraddr_d = wptr_q;
                    rdaddr_d = rptr_q;
                    if (pend_wr_q && full)  ovf_d = 1'b1;
                    if (pend_rd_q && empty) udf_d = 1'b1;
                end
            end
            S_XFER: begin
                wptr_d     = wptr_q + AW'(wren_q);
                rptr_d     = rptr_q + AW'(rden_q);
                cnt_d      = cnt_q + CW'(wren_q) - CW'(rden_q);
                rd_valid_d = rden_q;
                state_d    = rden_q ? S_RDLAT : S_IDLE;
            end
            S_RDLAT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            wraddr_q   <= '0;
            rdaddr_q   <= '0;
            cnt_q      <= '0;
            pend_wr_q  <= 1'b0;
            pend_rd_q  <= 1'b0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            wraddr_q   <= wraddr_d;
            rdaddr_q   <= rdaddr_d;
            cnt_q      <= cnt_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign ram.wren     = wren_q;
    assign ram.wraddr   = wraddr_q;
    assign ram.rden     = rden_q;
    assign ram.rdaddr   = rdaddr_q;
    assign ram.fifolen  = cnt_q;
    assign ram.full     = full;
    assign ram.empty    = empty;
    assign ram.rd_valid = rd_valid_q;
    assign ram.ovf_err  = ovf_q;
    assign ram.udf_err  = udf_q;
endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: events against a queue-based occupancy model, slot outputs checked by a monitor.
module tb_fifo_sched;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic auto_en = 1'b0, wr_tick = 1'b0, rd_tick = 1'b0;
    logic push_btn = 1'b0, pop_btn = 1'b0;

    fifo_sched_if bus ();

    fifo_sched dut (
        .clk(clk), .reset(reset), .auto_en(auto_en),
        .wr_tick(wr_tick), .rd_tick(rd_tick),
        .push_btn(push_btn), .pop_btn(pop_btn),
        .ram(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit w;
        int wa;
        bit r;
        int ra;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cnt, m_w, m_r;
    bit   m_ovf, m_udf;
    bit   prev_rden = 1'b0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick_n(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        sbq.delete();
        m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic chk_status(string tag);
        chk({tag, ".fifolen"}, bus.fifolen, m_cnt);
        chk({tag, ".full"},    bus.full,    (m_cnt == DEPTH) ? 1 : 0);
        chk({tag, ".empty"},   bus.empty,   (m_cnt == 0) ? 1 : 0);
        chk({tag, ".ovf_err"}, bus.ovf_err, m_ovf);
        chk({tag, ".udf_err"}, bus.udf_err, m_udf);
    endtask

    // Monitor: every presented slot is matched against the oldest expected transfer.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_rden = 1'b0;
        end else begin
            chk("rd_valid_follows_rden", bus.rd_valid, prev_rden);
            prev_rden = bus.rden;
            if (bus.wren || bus.rden) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_slot", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("slot.wren", bus.wren, e.w);
                    chk("slot.rden", bus.rden, e.r);
                    if (e.w) chk("slot.wraddr", bus.wraddr, e.wa);
                    if (e.r) chk("slot.rdaddr", bus.rdaddr, e.ra);
                end
            end
        end
    end

    task automatic do_reset(bit hold_push);
        reset = 1'b1; auto_en = 1'b0; wr_tick = 1'b0; rd_tick = 1'b0;
        push_btn = hold_push; pop_btn = 1'b0;
        tick_n(3);
        reset = 1'b0;
        model_clear();
        chk("rst.fifolen", bus.fifolen, 0);
        chk("rst.empty", bus.empty, 1);
        chk("rst.full", bus.full, 0);
        chk("rst.wren", bus.wren, 0);
        chk("rst.rden", bus.rden, 0);
        chk("rst.rd_valid", bus.rd_valid, 0);
        chk("rst.ovf_err", bus.ovf_err, 0);
        chk("rst.udf_err", bus.udf_err, 0);
        tick_n(1);
        push_btn = 1'b0;
        tick_n(5);
        if (hold_push) chk("held_through_reset.fifolen", bus.fifolen, 0);
    endtask

    // One isolated request event; acceptance follows the occupancy seen at slot time.
    task automatic do_event(bit p, bit q, bit use_auto, int hold, string tag);
        exp_t e;
        e.w  = p && (m_cnt < DEPTH);
        e.r  = q && (m_cnt > 0);
        e.wa = m_w;
        e.ra = m_r;
        if (p && !e.w) m_ovf = 1;
        if (q && !e.r) m_udf = 1;
        if (e.w || e.r) sbq.push_back(e);
        m_cnt = m_cnt + int'(e.w) - int'(e.r);
        m_w   = (m_w + int'(e.w)) % DEPTH;
        m_r   = (m_r + int'(e.r)) % DEPTH;
        if (use_auto) begin
            auto_en = 1'b1; wr_tick = p; rd_tick = q;
            tick_n(1);
            wr_tick = 1'b0; rd_tick = 1'b0;
        end else begin
            auto_en = 1'b0; push_btn = p; pop_btn = q;
            tick_n(hold);
            push_btn = 1'b0; pop_btn = 1'b0;
        end
        tick_n(6);
        chk_status(tag);
    endtask

    // Three back-to-back write ticks: two fit the pending latch, the third lands while it is busy.
    task automatic drop_burst();
        exp_t e;
        e.w = 1; e.r = 0; e.ra = 0;
        e.wa = m_w;            sbq.push_back(e);
        e.wa = (m_w + 1) % DEPTH; sbq.push_back(e);
        m_cnt += 2; m_w = (m_w + 2) % DEPTH; m_ovf = 1;
        auto_en = 1'b1; wr_tick = 1'b1;
        tick_n(3);
        wr_tick = 1'b0;
        tick_n(10);
        chk_status("drop_burst");
    endtask

    initial begin
        bit   found;
        exp_t e;

        do_reset(1'b1);
        do_event(1, 0, 0, 10, "hold_push");

        do_reset(1'b0);
        repeat (32) do_event(1, 0, 0, 2, "fill");
        do_event(1, 0, 0, 2, "push_full");
        repeat (32) do_event(0, 1, 0, 2, "drain");
        do_event(0, 1, 0, 2, "pop_empty");

        do_reset(1'b0);
        repeat (5) do_event(1, 0, 0, 2, "pre5");
        do_event(1, 1, 1, 1, "simul_ticks");

        do_reset(1'b0);
        repeat (31) do_event(1, 0, 1, 1, "wrap_fill");
        repeat (28) do_event(0, 1, 1, 1, "wrap_drain");
        do_event(1, 0, 0, 2, "wrap_push31");
        do_event(1, 0, 0, 2, "wrap_push0");

        do_reset(1'b0);
        drop_burst();

        for (int i = 0; i < 300; i++) begin
            bit p, q;
            if (i < 150) begin
                p = ($urandom_range(0, 3) != 0);
                q = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 3) == 0);
                q = ($urandom_range(0, 3) != 0);
            end
            do_event(p, q, 1'($urandom_range(0, 1)), $urandom_range(1, 4), "random");
        end

        // Reset landing in the middle of a transfer slot, with both error flags set beforehand.
        do_reset(1'b0);
        do_event(0, 1, 0, 2, "pre_udf");
        drop_burst();
        repeat (5) do_event(1, 0, 0, 2, "pre7");
        e.w = 1; e.wa = m_w; e.r = 0; e.ra = 0;
        sbq.push_back(e);
        auto_en = 1'b0; push_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (bus.wren) found = 1'b1;
        end
        chk("xfer_seen_before_reset", found, 1);
        #1;
        reset = 1'b1; push_btn = 1'b0;
        @(negedge clk);
        chk("mid_rst.fifolen", bus.fifolen, 0);
        chk("mid_rst.wren", bus.wren, 0);
        chk("mid_rst.rden", bus.rden, 0);
        chk("mid_rst.rd_valid", bus.rd_valid, 0);
        chk("mid_rst.ovf_err", bus.ovf_err, 0);
        chk("mid_rst.udf_err", bus.udf_err, 0);
        chk("mid_rst.empty", bus.empty, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        sbq.delete();
        tick_n(8);
        chk("post_rst.fifolen", bus.fifolen, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
endmodule
